fc_operand_feeder: RTL



---
 rtl/fc_operand_feeder_pkg.sv | 32 +++
 rtl/fc_operand_feeder_token_pipe.sv | 36 +++
 rtl/fc_operand_feeder.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/fc_operand_feeder_pkg.sv
// Shared types for the FC operand feeder: sequencer states, the in-flight
// chunk token, and a signed saturation helper also used by conv post-processing.
package fc_operand_feeder_pkg;

   localparam int TOK_IDX_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } fc_state_e;

   typedef struct packed {
      logic                 valid;
      logic                 last;
      logic [TOK_IDX_W-1:0] index;
   } fc_token_t;

   // Clamp a wide signed value into the range of a signed 'width'-bit word.
   function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                     input int width);
      logic signed [63:0] max_v;
      logic signed [63:0] min_v;
      max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
      min_v = -max_v - 64'sd1;
      if (value > max_v) return max_v;
      if (value < min_v) return min_v;
      return value;
   endfunction

endpackage

// File: rtl/fc_operand_feeder_token_pipe.sv
// Fixed-depth delay line that carries chunk tokens alongside the memory and
// dot-product latency, so each result meets its neuron/last tag.
module fc_token_pipe
   import fc_operand_feeder_pkg::*;
#(
   parameter int STAGES = 3
)(
   input  logic      clk,
   input  logic      rst,
   input  fc_token_t i_token,
   output fc_token_t o_token,
   output logic      o_empty
);

   fc_token_t pipe_q [STAGES];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < STAGES; i++) pipe_q[i] <= '0;
      end else begin
         pipe_q[0] <= i_token;
         for (int i = 1; i < STAGES; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   assign o_token = pipe_q[STAGES-1];

   // Empty after this shift: only the output stage may still hold a token.
   always_comb begin
      o_empty = !i_token.valid;
      for (int i = 0; i < STAGES - 1; i++) begin
         if (pipe_q[i].valid) o_empty = 1'b0;
      end
   end

endmodule

// File: rtl/fc_operand_feeder.sv
// Sequences feature/weight chunk reads into the 16-lane dot unit and
// accumulates the per-chunk results into one saturated output per neuron.
module fc_operand_feeder
   import fc_operand_feeder_pkg::*;
#(
   parameter int input_channel_num  = 16,
   parameter int word_size          = 16,
   parameter int chunk_num          = 25,
   parameter int output_channel_num = 100,
   parameter int mul_latency        = 1,
   localparam int VEC_W   = word_size * input_channel_num,
   localparam int FEAT_AW = (chunk_num > 1) ? $clog2(chunk_num) : 1,
   localparam int WGT_AW  = (chunk_num * output_channel_num > 1) ?
                            $clog2(chunk_num * output_channel_num) : 1,
   localparam int IDX_W   = (output_channel_num > 1) ? $clog2(output_channel_num) : 1
)(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        i_start,
   output logic                        o_busy,
   output logic                        o_done,
   output logic [FEAT_AW-1:0]          o_feat_addr,
   input  logic [VEC_W-1:0]            i_feat_data,
   output logic [WGT_AW-1:0]           o_wgt_addr,
   input  logic [VEC_W-1:0]            i_wgt_data,
   output logic [VEC_W-1:0]            o_fc_data,
   output logic [VEC_W-1:0]            o_fc_weight,
   input  logic signed [word_size-1:0] i_fc_result,
   output logic                        o_valid,
   output logic signed [word_size-1:0] o_result,
   output logic [IDX_W-1:0]            o_index
);

   localparam int ACC_W  = word_size + $clog2(chunk_num) + 1;
   localparam int STAGES = 2 + mul_latency;
   localparam logic [FEAT_AW-1:0] C_LAST = FEAT_AW'(chunk_num - 1);
   localparam logic [IDX_W-1:0]   N_LAST = IDX_W'(output_channel_num - 1);

   fc_state_e               state_q;
   fc_state_e               state_d;
   logic [FEAT_AW-1:0]      chunk_q;
   logic [IDX_W-1:0]        neuron_q;
   logic [WGT_AW-1:0]       wgt_addr_q;
   logic signed [ACC_W-1:0] acc_q;
   logic signed [ACC_W-1:0] res_ext;
   logic signed [ACC_W-1:0] acc_sum;
   logic signed [63:0]      sum_wide;
   logic signed [63:0]      sat_wide;
   fc_token_t               tok_in;
   fc_token_t               tok_out;
   logic                    pipe_empty;
   logic                    issue;
   logic                    chunk_last;
   logic                    layer_last;
   logic                    unused_bits;

   assign issue      = (state_q == ST_RUN);
   assign chunk_last = (chunk_q == C_LAST);
   assign layer_last = chunk_last && (neuron_q == N_LAST);

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (i_start) state_d = ST_RUN;
         ST_RUN:   if (layer_last) state_d = ST_DRAIN;
         ST_DRAIN: if (pipe_empty) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Issue stage: neuron-major, chunk-minor read addresses.
   always_ff @(posedge clk) begin
      if (rst) begin
         chunk_q    <= '0;
         neuron_q   <= '0;
         wgt_addr_q <= '0;
      end else if (issue) begin
         chunk_q    <= chunk_last ? '0 : chunk_q + FEAT_AW'(1);
         wgt_addr_q <= layer_last ? '0 : wgt_addr_q + WGT_AW'(1);
         if (chunk_last) neuron_q <= (neuron_q == N_LAST) ? '0 : neuron_q + IDX_W'(1);
      end
   end

   assign o_feat_addr = chunk_q;
   assign o_wgt_addr  = wgt_addr_q;
   assign o_busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign o_done      = (state_q == ST_DONE);

   always_comb begin
      tok_in       = '0;
      tok_in.valid = issue;
      tok_in.last  = chunk_last;
      tok_in.index = TOK_IDX_W'(neuron_q);
   end

   fc_token_pipe #(
      .STAGES (STAGES)
   ) u_token_pipe (
      .clk     (clk),
      .rst     (rst),
      .i_token (tok_in),
      .o_token (tok_out),
      .o_empty (pipe_empty)
   );

   // Operand stage: memory read data registered toward the dot unit.
   always_ff @(posedge clk) begin
      if (rst) begin
         o_fc_data   <= '0;
         o_fc_weight <= '0;
      end else begin
         o_fc_data   <= i_feat_data;
         o_fc_weight <= i_wgt_data;
      end
   end

   assign res_ext  = {{(ACC_W - word_size){i_fc_result[word_size-1]}}, i_fc_result};
   assign acc_sum  = acc_q + res_ext;
   assign sum_wide = {{(64 - ACC_W){acc_sum[ACC_W-1]}}, acc_sum};
   assign sat_wide = sat_signed(sum_wide, word_size);

   // Accumulate stage: the last chunk closes the neuron and restarts from zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
      end else if (tok_out.valid) begin
         acc_q <= tok_out.last ? '0 : acc_sum;
      end
   end

   assign o_valid     = !rst && tok_out.valid && tok_out.last;
   assign o_result    = o_valid ? sat_wide[word_size-1:0] : '0;
   assign o_index     = o_valid ? tok_out.index[IDX_W-1:0] : '0;
   assign unused_bits = ^{sat_wide[63:word_size], tok_out.index[TOK_IDX_W-1:IDX_W]};

endmodule
